lfsr_stream: RTL
================

# lfsr_stream

Parametrised Galois LFSR pseudo-random source with a valid/ready output stream, run-time seed loading, all-zero lockup protection and period measurement. It generalises the fixed 8-bit LFSR with taps x^8+x^4+x^3+x^2+1 to any width and polynomial. It feeds test-pattern generators, scramblers and stimulus paths that consume one value per handshake.

## Interface
- WIDTH, 8: LFSR state width; legal range 3..32.
- TAPS, 8'h1D: Galois feedback mask, WIDTH bits. Bit i set means the MSB is XORed into bit i. TAPS[0] must be 1; elaboration fails otherwise.
- DEFAULT_SEED, 8'h01: reset seed and zero-seed substitute. Must be non-zero.
- clk  in  1  single clock; all logic updates on the rising edge.
- res  in  1  synchronous, active-high reset.
- en  in  1  generator enable; permits a new value to be presented.
- seed_load  in  1  one-cycle strobe that loads seed_in; highest priority after res.
- seed_in  in  WIDTH  seed value, sampled when seed_load=1.
- out_valid  out  1  out_data holds an unconsumed value.
- out_ready  in  1  consumer accepts out_data when out_valid=1.
- out_data  out  WIDTH  current LFSR state.
- zero_seed  out  1  sticky flag: an all-zero seed was loaded and replaced.
- period_done  out  1  one-cycle pulse when the sequence returns to its start value.
- period_len  out  WIDTH  length of the last completed period. 0 means no period has completed.

## Operation
- Next-state function: next = (state << 1) ^ (state[WIDTH-1] ? TAPS : 0), truncated to WIDTH bits.
- The next state is never all-zero when state is non-zero.
- Transfer: out_valid=1 and out_ready=1 on the same edge.
- Advance rule: the state advances exactly once per transfer and never otherwise. en does not advance the state by itself.
- out_valid behaviour:
  - Goes 0→1 on any cycle with en=1 and out_valid=0.
  - After a transfer, stays 1 if en=1 that cycle, else drops to 0.
  - Once 1, holds until a transfer, seed_load or res. Dropping en does not retract it.
- out_data is stable while out_valid=1 and out_ready=0.
- Seed load (seed_load=1):
  - state ← seed_in, or DEFAULT_SEED if seed_in==0; in the zero case zero_seed ← 1.
  - start ← the loaded value; step_cnt ← 0; out_valid ← 0.
  - Any simultaneous transfer is discarded: the state is not advanced and the value counts as not consumed.
- Period tracking:
  - Internal register start (WIDTH) and counter step_cnt (WIDTH).
  - On each transfer: if next==start, pulse period_done, set period_len ← step_cnt+1 and set step_cnt ← 0. Otherwise step_cnt increments.
  - step_cnt cannot overflow, because the maximum period is 2^WIDTH−1.
  - For a non-primitive TAPS, period_len reports the actual cycle length of the seed's orbit.
- zero_seed clears only on res.
- Priority, highest first: res > seed_load > transfer/en logic.

## Timing
- Reset values:
  - state=DEFAULT_SEED, start=DEFAULT_SEED
  - out_valid=0, step_cnt=0, period_len=0, period_done=0, zero_seed=0
- Latency from reset or seed_load to the first out_valid=1: one edge with en=1 (earliest is the edge after the load cycle).
- Throughput: one value per clock while en=1 and out_ready=1.
- period_done is registered. It is high in the cycle after the wrapping transfer, at the same time out_data==start is visible. period_len updates on that same edge.
- res mid-stream: all state returns to reset values on that edge. Any in-flight value is lost and no period_done is produced.
- seed_load with res: res wins.
- seed_load on consecutive cycles: the last one wins, and out_valid stays 0.

## Test plan
- Reset sequence, WIDTH=8, TAPS=8'h1D: assert res, then hold en=1 and out_ready=1. out_data must read 01, 02, 04, 08, 10, 20, 40, 80, 1D, 3A, with out_valid=1 from the second post-reset edge onward.
- Backpressure: en=1, toggle out_ready in the pattern 1,0,0,1. out_data must hold through the ready=0 cycles, and each value must appear exactly once per transfer with no skips.
- Full period, seed 8'h01: run 255 transfers. period_done must pulse once as out_data returns to 01, and period_len must read 255 (8'hFF). No value may repeat within the period, and 8'h00 must never appear.
- Zero seed: seed_load=1 with seed_in=8'h00. Next cycle: out_data=01, zero_seed=1, out_valid=0. zero_seed must stay 1 after subsequent seed loads until res.
- Seed load during transfer: with out_valid=1 and out_data=04, assert seed_load (seed_in=8'hA5) and out_ready=1 together. Next cycle: out_data=A5, out_valid=0, and the 04→08 advance must not occur. step_cnt restarts, so the next period_len is 255.
- Parameter sweep: WIDTH=4, TAPS=4'h3, seed 4'h1. Sequence 1,2,4,8,3,6,C,B,5,A,7,E,F,D,9, then 1. period_done must fire with period_len=15.

Source files
------------

// File: rtl/lfsr_stream.sv
// -----------------------------------------------------------------------------
// lfsr_stream
//
// Parametrised Galois LFSR pseudo-random source presented as a valid/ready
// stream. Each accepted value (out_valid & out_ready) advances the LFSR once.
// A run-time seed can be loaded; an all-zero seed is replaced by DEFAULT_SEED
// and flagged. The block also measures the length of the orbit it is walking
// by counting transfers until the state returns to the value it started from.
//
// Parameters:
//   WIDTH        LFSR state width (3..32)
//   TAPS         Galois feedback mask; bit i set -> MSB is XORed into bit i
//   DEFAULT_SEED reset seed and replacement for an all-zero seed
//
// Ports:
//   clk          clock, rising edge
//   res          synchronous active-high reset
//   en           generator enable; allows a new value to be presented
//   seed_load    one-cycle strobe, loads seed_in (discards any transfer)
//   seed_in      seed value sampled with seed_load
//   out_valid    out_data holds an unconsumed value
//   out_ready    consumer accepts out_data when out_valid is high
//   out_data     current LFSR state
//   zero_seed    sticky: an all-zero seed was loaded and replaced
//   period_done  one-cycle pulse when the sequence returned to its start value
//   period_len   length of the last completed period (0 = none yet)
// -----------------------------------------------------------------------------
module lfsr_stream #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'h1D,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             zero_seed,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len
);

    // Parameter sanity: a Galois LFSR without the x^0 tap is not invertible
    // and can collapse to zero; a zero default seed would lock up.
    generate
        if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
            $error("lfsr_stream: WIDTH must be in 3..32");
        end
        if (TAPS[0] != 1'b1) begin : g_bad_taps
            $error("lfsr_stream: TAPS[0] must be 1");
        end
        if (DEFAULT_SEED == '0) begin : g_bad_seed
            $error("lfsr_stream: DEFAULT_SEED must be non-zero");
        end
    endgenerate

    // Galois step: shift left, fold the outgoing MSB back in through TAPS.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : '0);
    endfunction

    logic [WIDTH-1:0] state_q,       state_d;
    logic [WIDTH-1:0] start_q,       start_d;
    logic [WIDTH-1:0] step_cnt_q,    step_cnt_d;
    logic [WIDTH-1:0] period_len_q,  period_len_d;
    logic             valid_q,       valid_d;
    logic             period_done_q, period_done_d;
    logic             zero_seed_q,   zero_seed_d;

    logic             xfer;
    logic [WIDTH-1:0] state_nxt;
    logic             seed_is_zero;

    assign xfer         = valid_q & out_ready;
    assign state_nxt    = lfsr_next(state_q);
    assign seed_is_zero = (seed_in == '0);

    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        step_cnt_d    = step_cnt_q;
        period_len_d  = period_len_q;
        valid_d       = valid_q;
        period_done_d = 1'b0;
        zero_seed_d   = zero_seed_q;

        if (seed_load) begin
            // A coincident transfer is dropped: the value counts as unconsumed
            // and the state is overwritten rather than advanced.
            state_d     = seed_is_zero ? DEFAULT_SEED : seed_in;
            start_d     = seed_is_zero ? DEFAULT_SEED : seed_in;
            step_cnt_d  = '0;
            valid_d     = 1'b0;
            zero_seed_d = zero_seed_q | seed_is_zero;
        end else if (xfer) begin
            state_d = state_nxt;
            valid_d = en;
            // step_cnt counts transfers since start; the wrapping transfer
            // is the (step_cnt+1)-th. Max period 2^WIDTH-1 fits in WIDTH bits.
            if (state_nxt == start_q) begin
                period_done_d = 1'b1;
                period_len_d  = step_cnt_q + WIDTH'(1);
                step_cnt_d    = '0;
            end else begin
                step_cnt_d = step_cnt_q + WIDTH'(1);
            end
        end else if (en) begin
            // Present the current state; once valid it holds until consumed.
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q       <= DEFAULT_SEED;
            start_q       <= DEFAULT_SEED;
            step_cnt_q    <= '0;
            period_len_q  <= '0;
            valid_q       <= 1'b0;
            period_done_q <= 1'b0;
            zero_seed_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            step_cnt_q    <= step_cnt_d;
            period_len_q  <= period_len_d;
            valid_q       <= valid_d;
            period_done_q <= period_done_d;
            zero_seed_q   <= zero_seed_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = state_q;
    assign zero_seed   = zero_seed_q;
    assign period_done = period_done_q;
    assign period_len  = period_len_q;

endmodule
